ins_fetcher: RTL and testbench
==============================

# ins_fetcher

Instruction fetch stage: owns the PC, issues one-at-a-time word requests to the instruction cache, and buffers returned instructions with their PC in a small FIFO. Sits directly upstream of the decoder/issue stage: the queue head supplies the 32-bit `code` the decoder consumes, plus its PC. A flush from the ROB/branch unit discards all queued and in-flight instructions and redirects fetch.

## Interface
- `QUEUE_DEPTH`, 8, queue entries; power of two, ≥2
- `RESET_PC`, 32'h0, PC loaded at reset
- `clk_in`  in  1  clock; all state updates on rising edge
- `rst_in`  in  1  reset; one clock, reset is synchronous and active-low
- `rdy_in`  in  1  global ready; low freezes all state, outputs hold
- `icache_req_valid`  out  1  fetch request pending
- `icache_req_addr`  out  32  word address to fetch
- `icache_resp_valid`  in  1  one-cycle pulse: `icache_resp_data` valid for current request
- `icache_resp_data`  in  32  fetched instruction word
- `flush_in`  in  1  mispredict/redirect pulse
- `flush_pc_in`  in  32  new fetch PC when `flush_in`=1
- `ins_valid`  out  1  queue head valid
- `ins_ready`  in  1  decoder/issue accepts head this cycle
- `ins_code`  out  32  head instruction word
- `ins_pc`  out  32  head instruction PC
- `ins_pred_jump`  out  1  head was redirected by fetch predecode (0 if feature off)

## Operation
- State machine: IDLE (no request out), WAIT (request out, response expected), DROP (request out, response to be discarded).
- IDLE→WAIT when `count + 1 ≤ QUEUE_DEPTH` after this cycle's dequeue, i.e. a free slot is reserved for the in-flight word; `icache_req_addr`=`pc`.
- WAIT: `icache_req_valid`=1, addr held stable until `icache_resp_valid`. On response: enqueue {data, pc, pred}; advance `pc` (+4, or predecode target); go WAIT again if a slot remains, else IDLE.
- DROP: `icache_req_valid`=1 with old addr; on response discard data, go IDLE. Cache protocol forbids cancelling a request.
- Flush (highest priority): queue emptied (`count`=0, head=tail), `pc`=`flush_pc_in`; WAIT→DROP, DROP stays DROP, IDLE stays IDLE. A response arriving in the flush cycle is discarded; flush from WAIT with response same cycle → IDLE. Dequeue in flush cycle is void.
- Simultaneous enqueue and dequeue: both occur, `count` unchanged; legal when full since slot was reserved.
- Pointers wrap modulo `QUEUE_DEPTH`; `count` width log2(DEPTH)+1.
- `rdy_in`=0: no state change, responses ignored (cache is frozen by same signal).

## Timing
- Reset values: `pc`=`RESET_PC`, state IDLE, `count`=0; `icache_req_valid`=0, `icache_req_addr`=`RESET_PC`, `ins_valid`=0, `ins_code`=0, `ins_pc`=0, `ins_pred_jump`=0.
- Reset mid-operation overrides flush; outstanding response after reset is not consumed (cache is reset together).
- First request: cycle after reset release. Response in cycle t → `ins_valid`=1 in t+1. Next request asserted in t+1.
- `ins_*` driven from registered queue storage; head stable while `ins_valid`=1 and `ins_ready`=0.
- Throughput: one instruction per cache round trip (single outstanding request).

## Configuration
- `FETCH_PREDECODE_EN` defined: on response with `data[6:0]`=7'h6F (JAL), next `pc` = pc + J-immediate (sign-extended {data[31], data[19:12], data[20], data[30:21], 1'b0}); entry `pred`=1.
- Undefined: next `pc` always pc+4; `ins_pred_jump` tied 0; JAL resolved downstream via flush.

## Structure
- Shared package/`define.v`: `INS_WIDTH`, `DATA_WIDTH`, opcode constant JAL 7'h6F, fetch state encodings.
- Sub-module `ins_queue`: parameterised FIFO (enq/deq, count, full/empty, clear) holding {code, pc, pred}; fetcher holds PC, FSM, predecode.

## Test plan
- Reset, cache returns 32'h00000013 at 0,4,8 with 1-cycle latency, `ins_ready`=1 → `ins_pc` sequence 0,4,8, each `ins_valid` one cycle after response.
- `ins_ready`=0, DEPTH=8 → exactly 8 entries filled, `icache_req_valid` low thereafter; release one → one new request.
- Flush to 32'h100 while WAIT, stale response arrives 3 cycles later → stale word never appears; next `ins_pc`=32'h100.
- Flush coincident with response and dequeue → queue empty next cycle, state IDLE, then request at 32'h100.
- With `FETCH_PREDECODE_EN`, JAL 32'h0080006F at pc 0x20 → next request 0x28, entry `ins_pred_jump`=1; without macro → request 0x24, flag 0.
- `rdy_in` low 5 cycles mid-WAIT → all outputs and addr held; resumes identically.

Source files
------------

// File: rtl/ins_fetcher_pkg.sv
// Shared types for the instruction fetch stage: widths, JAL opcode, FSM states,
// queue entry layout and the JAL immediate decoder used by predecode.
package ins_fetcher_pkg;

   localparam int INS_WIDTH  = 32;
   localparam int DATA_WIDTH = 32;

   localparam logic [6:0] OPC_JAL = 7'h6F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INS_WIDTH-1:0]  code;
      logic [DATA_WIDTH-1:0] pc;
      logic                  pred;
   } queue_entry_t;

   // Sign-extended J-type immediate: {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
   function automatic logic [DATA_WIDTH-1:0] jal_offset(input logic [INS_WIDTH-1:0] ins);
      return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/ins_queue.sv
// Circular FIFO of fetched {code, pc, pred} entries with synchronous clear.
// Everything freezes while en_i is low; head_o comes straight from storage.
module ins_queue
   import ins_fetcher_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic                     clr_i,
   input  logic                     enq_i,
   input  queue_entry_t             enq_data_i,
   input  logic                     deq_i,
   output queue_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   queue_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   head_q;
   logic [PW-1:0]   tail_q;
   logic [CW-1:0]   count_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (en_i) begin
         if (clr_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (enq_i) begin
               mem_q[tail_q] <= enq_data_i;
               tail_q        <= tail_q + 1'b1;
            end
            if (deq_i) begin
               head_q <= head_q + 1'b1;
            end
            // Power-of-two depth lets the pointers wrap by plain overflow.
            count_q <= count_q + CW'(enq_i) - CW'(deq_i);
         end
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetch: PC, single-outstanding icache request FSM and fetch queue.
// Optional JAL predecode redirect is enabled by defining FETCH_PREDECODE_EN.
module ins_fetcher
   import ins_fetcher_pkg::*;
#(
   parameter int          QUEUE_DEPTH = 8,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        icache_req_valid,
   output logic [31:0] icache_req_addr,
   input  logic        icache_resp_valid,
   input  logic [31:0] icache_resp_data,
   input  logic        flush_in,
   input  logic [31:0] flush_pc_in,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [31:0] ins_code,
   output logic [31:0] ins_pc,
   output logic        ins_pred_jump,
   output logic [1:0]  dbg_state_o
);

   localparam int              CW      = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(QUEUE_DEPTH);

   fetch_state_e    state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     drop_addr_q, drop_addr_d;

   logic            enq, deq, clr;
   queue_entry_t    enq_entry, head;
   logic [CW-1:0]   count, count_after;
   logic            full, empty;
   logic [31:0]     next_pc;
   logic            pred_jump;

   // Handshake: the head moves on a clock edge where ins_valid && ins_ready && rdy_in
   // and no flush; the icache sees icache_req_valid with a stable address until
   // icache_resp_valid, and a request is never withdrawn.
   assign deq         = ins_valid && ins_ready && !flush_in;
   assign count_after = count - CW'(deq);

   always_comb begin
      next_pc   = pc_q + 32'd4;
      pred_jump = 1'b0;
`ifdef FETCH_PREDECODE_EN
      if (icache_resp_data[6:0] == OPC_JAL) begin
         next_pc   = pc_q + jal_offset(icache_resp_data);
         pred_jump = 1'b1;
      end
`endif
   end

   assign enq_entry = '{code: icache_resp_data, pc: pc_q, pred: pred_jump};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      enq         = 1'b0;
      clr         = 1'b0;
      if (flush_in) begin
         clr  = 1'b1;
         pc_d = flush_pc_in;
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_WAIT: begin
               drop_addr_d = pc_q;
               state_d     = icache_resp_valid ? ST_IDLE : ST_DROP;
            end
            ST_DROP: state_d = icache_resp_valid ? ST_IDLE : ST_DROP;
            default: state_d = ST_IDLE;
         endcase
      end else begin
         case (state_q)
            // A request reserves its slot, so issue only when one is free.
            ST_IDLE: if (!full || deq) state_d = ST_WAIT;
            ST_WAIT: begin
               if (icache_resp_valid) begin
                  enq     = 1'b1;
                  pc_d    = next_pc;
                  state_d = ((count_after + 1'b1) < DEPTH_C) ? ST_WAIT : ST_IDLE;
               end
            end
            ST_DROP: if (icache_resp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         drop_addr_q <= RESET_PC;
      end else if (rdy_in) begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   ins_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk_i      (clk_in),
      .rst_ni     (rst_in),
      .en_i       (rdy_in),
      .clr_i      (clr),
      .enq_i      (enq),
      .enq_data_i (enq_entry),
      .deq_i      (deq),
      .head_o     (head),
      .count_o    (count),
      .full_o     (full),
      .empty_o    (empty)
   );

   assign icache_req_valid = (state_q != ST_IDLE);
   assign icache_req_addr  = (state_q == ST_DROP) ? drop_addr_q : pc_q;
   assign ins_valid        = !empty;
   assign ins_code         = head.code;
   assign ins_pc           = head.pc;
   assign ins_pred_jump    = head.pred;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_ins_fetcher.sv
// Bench for ins_fetcher: directed scenarios plus a randomized run against a queue model.
// Expectations follow FETCH_PREDECODE_EN when it is defined for the build.
module tb_ins_fetcher;
   import ins_fetcher_pkg::*;

   localparam int DEPTH = 8;
`ifdef FETCH_PREDECODE_EN
   localparam logic [31:0] EXP_JAL_TGT  = 32'h28;
   localparam logic        EXP_JAL_PRED = 1'b1;
`else
   localparam logic [31:0] EXP_JAL_TGT  = 32'h24;
   localparam logic        EXP_JAL_PRED = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        icache_req_valid;
   logic [31:0] icache_req_addr;
   logic        icache_resp_valid = 1'b0;
   logic [31:0] icache_resp_data  = '0;
   logic        flush_in          = 1'b0;
   logic [31:0] flush_pc_in       = '0;
   logic        ins_valid;
   logic        ins_ready         = 1'b0;
   logic [31:0] ins_code;
   logic [31:0] ins_pc;
   logic        ins_pred_jump;
   logic [1:0]  dbg_state_o;

   int checks   = 0;
   int failures = 0;
   logic [64:0] exp_q[$];

   ins_fetcher #(
      .QUEUE_DEPTH (DEPTH),
      .RESET_PC    (32'h0)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .rdy_in            (rdy_in),
      .icache_req_valid  (icache_req_valid),
      .icache_req_addr   (icache_req_addr),
      .icache_resp_valid (icache_resp_valid),
      .icache_resp_data  (icache_resp_data),
      .flush_in          (flush_in),
      .flush_pc_in       (flush_pc_in),
      .ins_valid         (ins_valid),
      .ins_ready         (ins_ready),
      .ins_code          (ins_code),
      .ins_pc            (ins_pc),
      .ins_pred_jump     (ins_pred_jump),
      .dbg_state_o       (dbg_state_o)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] d);
      logic [20:0] imm;
      imm = {d[31], d[19:12], d[20], d[30:21], 1'b0};
`ifdef FETCH_PREDECODE_EN
      if (d[6:0] == 7'h6F) return pc + {{11{imm[20]}}, imm};
`endif
      return pc + 32'd4;
   endfunction

   function automatic logic model_pred(input logic [31:0] d);
`ifdef FETCH_PREDECODE_EN
      return (d[6:0] == 7'h6F);
`else
      return 1'b0 & d[0];
`endif
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      rdy_in            = 1'b1;
      icache_resp_valid = 1'b0;
      icache_resp_data  = '0;
      flush_in          = 1'b0;
      flush_pc_in       = '0;
      ins_ready         = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_in = 1'b0;
      tick();
      tick();
      rst_in = 1'b1;
   endtask

   task automatic wait_req(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (icache_req_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s_req_timeout: icache_req_valid=%b required=1 within 20 cycles", name, icache_req_valid);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_in = 1'b0;
      tick();
      tick();
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 1) begin
            rst_in = 1'b1;
            tick();
            tick();
            icache_resp_valid = 1'b1;
            icache_resp_data  = 32'h13;
            tick();
            icache_resp_valid = 1'b0;
            // reset must win over a simultaneous flush
            rst_in      = 1'b0;
            flush_in    = 1'b1;
            flush_pc_in = 32'h200;
            tick();
            flush_in = 1'b0;
         end
         checks++;
         if (icache_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid ph=%0d got=%b required=0", ph, icache_req_valid); end
         checks++;
         if (icache_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr ph=%0d got=%h required=0", ph, icache_req_addr); end
         checks++;
         if (ins_valid !== 1'b0) begin failures++; $display("FAIL reset_ins_valid ph=%0d got=%b required=0", ph, ins_valid); end
         checks++;
         if (ins_code !== 32'h0) begin failures++; $display("FAIL reset_ins_code ph=%0d got=%h required=0", ph, ins_code); end
         checks++;
         if (ins_pc !== 32'h0) begin failures++; $display("FAIL reset_ins_pc ph=%0d got=%h required=0", ph, ins_pc); end
         checks++;
         if (ins_pred_jump !== 1'b0) begin failures++; $display("FAIL reset_pred ph=%0d got=%b required=0", ph, ins_pred_jump); end
         checks++;
         if (dbg_state_o !== ST_IDLE) begin failures++; $display("FAIL reset_state ph=%0d got=%0d required=%0d", ph, dbg_state_o, ST_IDLE); end
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      bit ok;
      do_reset();
      ins_ready = 1'b1;
      exp_pc    = 32'h0;
      checks++;
      if (icache_req_valid !== 1'b0) begin failures++; $display("FAIL seq_no_req_before_first got=%b required=0", icache_req_valid); end
      tick();
      for (int k = 0; k < 3; k++) begin
         wait_req("seq", ok);
         if (!ok) return;
         checks++;
         if (icache_req_addr !== exp_pc) begin failures++; $display("FAIL seq_req_addr k=%0d got=%h required=%h", k, icache_req_addr, exp_pc); end
         tick();
         icache_resp_valid = 1'b1;
         icache_resp_data  = 32'h00000013;
         tick();
         icache_resp_valid = 1'b0;
         checks++;
         if (ins_valid !== 1'b1 || ins_pc !== exp_pc || ins_code !== 32'h13) begin
            failures++;
            $display("FAIL seq_head k=%0d got valid=%b pc=%h code=%h required 1/%h/00000013", k, ins_valid, ins_pc, ins_code, exp_pc);
         end
         checks++;
         if (icache_req_valid !== 1'b1 || icache_req_addr !== exp_pc + 32'd4) begin
            failures++;
            $display("FAIL seq_next_req k=%0d got valid=%b addr=%h required 1/%h", k, icache_req_valid, icache_req_addr, exp_pc + 32'd4);
         end
         exp_pc = exp_pc + 32'd4;
      end
      tick();
      checks++;
      if (ins_valid !== 1'b0) begin failures++; $display("FAIL seq_drained got=%b required=0", ins_valid); end
      ins_ready = 1'b0;
   endtask

   task automatic test_fill();
      logic [31:0] d;
      logic [64:0] e;
      int n;
      do_reset();
      exp_q.delete();
      tick();
      n = 0;
      for (int c = 0; c < 40 && n < DEPTH; c++) begin
         if (icache_req_valid === 1'b1) begin
            checks++;
            if (icache_req_addr !== 32'(4 * n)) begin failures++; $display("FAIL fill_req_addr n=%0d got=%h required=%h", n, icache_req_addr, 32'(4 * n)); end
            d = $urandom();
            d[6:0] = 7'h13;
            icache_resp_valid = 1'b1;
            icache_resp_data  = d;
            exp_q.push_back({d, 32'(4 * n), 1'b0});
            n++;
         end else begin
            icache_resp_valid = 1'b0;
         end
         tick();
      end
      icache_resp_valid = 1'b0;
      checks++;
      if (n !== DEPTH) begin failures++; $display("FAIL fill_count got=%0d required=%0d", n, DEPTH); end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (icache_req_valid !== 1'b0 || ins_valid !== 1'b1) begin
            failures++;
            $display("FAIL fill_stall c=%0d got req=%b valid=%b required 0/1", c, icache_req_valid, ins_valid);
         end
         tick();
      end
      ins_ready = 1'b1;
      e = exp_q.pop_front();
      checks++;
      if (ins_pc !== e[32:1] || ins_code !== e[64:33]) begin failures++; $display("FAIL fill_release_head got pc=%h code=%h required %h/%h", ins_pc, ins_code, e[32:1], e[64:33]); end
      tick();
      ins_ready = 1'b0;
      checks++;
      if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'(4 * DEPTH)) begin
         failures++;
         $display("FAIL fill_refetch got valid=%b addr=%h required 1/%h", icache_req_valid, icache_req_addr, 32'(4 * DEPTH));
      end
      d = $urandom();
      d[6:0] = 7'h13;
      icache_resp_valid = 1'b1;
      icache_resp_data  = d;
      exp_q.push_back({d, 32'(4 * DEPTH), 1'b0});
      tick();
      icache_resp_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (icache_req_valid !== 1'b0) begin failures++; $display("FAIL fill_single_refetch c=%0d got=%b required=0", c, icache_req_valid); end
         tick();
      end
      ins_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (ins_valid !== 1'b1 || ins_pc !== e[32:1] || ins_code !== e[64:33]) begin
            failures++;
            $display("FAIL fill_drain i=%0d got valid=%b pc=%h code=%h required 1/%h/%h", i, ins_valid, ins_pc, ins_code, e[32:1], e[64:33]);
         end
         tick();
      end
      ins_ready = 1'b0;
   endtask

   task automatic test_flush_wait();
      do_reset();
      ins_ready = 1'b1;
      tick();
      flush_in    = 1'b1;
      flush_pc_in = 32'h100;
      tick();
      flush_in = 1'b0;
      checks++;
      if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0 || dbg_state_o !== ST_DROP) begin
         failures++;
         $display("FAIL flushw_drop got valid=%b addr=%h state=%0d required 1/0/%0d", icache_req_valid, icache_req_addr, dbg_state_o, ST_DROP);
      end
      tick();
      tick();
      icache_resp_valid = 1'b1;
      icache_resp_data  = 32'hDEADBEEF;
      tick();
      icache_resp_valid = 1'b0;
      checks++;
      if (ins_valid !== 1'b0 || icache_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL flushw_stale got valid=%b req=%b required 0/0", ins_valid, icache_req_valid);
      end
      tick();
      checks++;
      if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h100) begin
         failures++;
         $display("FAIL flushw_redirect got valid=%b addr=%h required 1/00000100", icache_req_valid, icache_req_addr);
      end
      icache_resp_valid = 1'b1;
      icache_resp_data  = 32'h13;
      tick();
      icache_resp_valid = 1'b0;
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 32'h100 || ins_code !== 32'h13) begin
         failures++;
         $display("FAIL flushw_head got valid=%b pc=%h code=%h required 1/00000100/00000013", ins_valid, ins_pc, ins_code);
      end
      tick();
      ins_ready = 1'b0;
   endtask

   task automatic test_flush_coincident();
      do_reset();
      ins_ready = 1'b1;
      tick();
      icache_resp_valid = 1'b1;
      icache_resp_data  = 32'h13;
      tick();
      // head is valid; flush, response and dequeue all land on one edge
      flush_in          = 1'b1;
      flush_pc_in       = 32'h100;
      icache_resp_data  = 32'h00100093;
      tick();
      flush_in          = 1'b0;
      icache_resp_valid = 1'b0;
      checks++;
      if (ins_valid !== 1'b0 || dbg_state_o !== ST_IDLE || icache_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL flushc_empty got valid=%b state=%0d req=%b required 0/%0d/0", ins_valid, dbg_state_o, icache_req_valid, ST_IDLE);
      end
      tick();
      checks++;
      if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h100) begin
         failures++;
         $display("FAIL flushc_redirect got valid=%b addr=%h required 1/00000100", icache_req_valid, icache_req_addr);
      end
      ins_ready = 1'b0;
   endtask

   task automatic test_predecode();
      logic [31:0] exp_addr, d;
      bit ok;
      do_reset();
      ins_ready = 1'b1;
      exp_addr  = 32'h0;
      tick();
      for (int k = 0; k < 9; k++) begin
         wait_req("pred", ok);
         if (!ok) return;
         checks++;
         if (icache_req_addr !== exp_addr) begin failures++; $display("FAIL pred_req_addr k=%0d got=%h required=%h", k, icache_req_addr, exp_addr); end
         d = (exp_addr == 32'h20) ? 32'h0080006F : 32'h00000013;
         icache_resp_valid = 1'b1;
         icache_resp_data  = d;
         tick();
         icache_resp_valid = 1'b0;
         checks++;
         if (ins_valid !== 1'b1 || ins_pc !== exp_addr || ins_pred_jump !== model_pred(d)) begin
            failures++;
            $display("FAIL pred_head k=%0d got valid=%b pc=%h pred=%b required 1/%h/%b", k, ins_valid, ins_pc, ins_pred_jump, exp_addr, model_pred(d));
         end
         exp_addr = model_next(exp_addr, d);
      end
      checks++;
      if (ins_pc !== 32'h20 || ins_pred_jump !== EXP_JAL_PRED) begin
         failures++;
         $display("FAIL pred_jal_flag got pc=%h pred=%b required 00000020/%b", ins_pc, ins_pred_jump, EXP_JAL_PRED);
      end
      checks++;
      if (icache_req_valid !== 1'b1 || icache_req_addr !== EXP_JAL_TGT) begin
         failures++;
         $display("FAIL pred_jal_target got valid=%b addr=%h required 1/%h", icache_req_valid, icache_req_addr, EXP_JAL_TGT);
      end
      tick();
      ins_ready = 1'b0;
   endtask

   task automatic test_rdy_freeze();
      do_reset();
      tick();
      icache_resp_valid = 1'b1;
      icache_resp_data  = 32'h13;
      tick();
      rdy_in            = 1'b0;
      ins_ready         = 1'b1;
      icache_resp_data  = 32'hDEADBEEF;
      flush_in          = 1'b1;
      flush_pc_in       = 32'h300;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h4 || ins_valid !== 1'b1 ||
             ins_pc !== 32'h0 || ins_code !== 32'h13 || dbg_state_o !== ST_WAIT) begin
            failures++;
            $display("FAIL rdy_hold c=%0d got req=%b addr=%h valid=%b pc=%h code=%h state=%0d required 1/4/1/0/13/%0d",
                     c, icache_req_valid, icache_req_addr, ins_valid, ins_pc, ins_code, dbg_state_o, ST_WAIT);
         end
      end
      idle_inputs();
      icache_resp_valid = 1'b1;
      icache_resp_data  = 32'h00000033;
      tick();
      icache_resp_valid = 1'b0;
      ins_ready         = 1'b1;
      checks++;
      if (ins_pc !== 32'h0 || ins_code !== 32'h13) begin failures++; $display("FAIL rdy_resume0 got pc=%h code=%h required 0/13", ins_pc, ins_code); end
      tick();
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 32'h4 || ins_code !== 32'h33) begin
         failures++;
         $display("FAIL rdy_resume1 got valid=%b pc=%h code=%h required 1/4/33", ins_valid, ins_pc, ins_code);
      end
      tick();
      ins_ready = 1'b0;
      checks++;
      if (ins_valid !== 1'b0) begin failures++; $display("FAIL rdy_resume_empty got=%b required=0", ins_valid); end
   endtask

   task automatic test_random();
      logic        outstanding, stale;
      int          lat;
      logic [31:0] model_pc, req_addr_m, r;
      logic [64:0] e;
      do_reset();
      exp_q.delete();
      outstanding = 1'b0;
      stale       = 1'b0;
      lat         = 0;
      model_pc    = 32'h0;
      req_addr_m  = 32'h0;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         checks++;
         if (ins_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL rnd_valid cyc=%0d got=%b required=%b", cyc, ins_valid, exp_q.size() != 0);
         end
         if (outstanding) begin
            checks++;
            if (icache_req_valid !== 1'b1 || icache_req_addr !== req_addr_m) begin
               failures++;
               $display("FAIL rnd_req_hold cyc=%0d got valid=%b addr=%h required 1/%h", cyc, icache_req_valid, icache_req_addr, req_addr_m);
            end
         end else if (icache_req_valid === 1'b1) begin
            checks++;
            if (icache_req_addr !== model_pc) begin
               failures++;
               $display("FAIL rnd_req_addr cyc=%0d got=%h required=%h", cyc, icache_req_addr, model_pc);
            end
            checks++;
            if (exp_q.size() >= DEPTH) begin
               failures++;
               $display("FAIL rnd_no_slot cyc=%0d queued=%0d required<%0d", cyc, exp_q.size(), DEPTH);
            end
            outstanding = 1'b1;
            stale       = 1'b0;
            req_addr_m  = model_pc;
            lat         = $urandom_range(0, 3);
         end

         rdy_in      = ($urandom_range(0, 9) != 0);
         ins_ready   = ($urandom_range(0, 2) != 0);
         flush_in    = ($urandom_range(0, 29) == 0);
         r           = $urandom();
         flush_pc_in = {r[31:2], 2'b00};
         r           = $urandom();
         if ($urandom_range(0, 4) == 0) r[6:0] = 7'h6F;
         icache_resp_valid = outstanding && (lat == 0);
         icache_resp_data  = r;

         if (rdy_in) begin
            if (ins_valid === 1'b1 && ins_ready && !flush_in && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               checks++;
               if (ins_code !== e[64:33] || ins_pc !== e[32:1] || ins_pred_jump !== e[0]) begin
                  failures++;
                  $display("FAIL rnd_deq cyc=%0d got code=%h pc=%h pred=%b required %h/%h/%b",
                           cyc, ins_code, ins_pc, ins_pred_jump, e[64:33], e[32:1], e[0]);
               end
            end
            if (flush_in) begin
               exp_q.delete();
               model_pc = flush_pc_in;
               if (outstanding) begin
                  if (icache_resp_valid) outstanding = 1'b0;
                  else stale = 1'b1;
               end
            end else if (icache_resp_valid) begin
               outstanding = 1'b0;
               if (!stale) begin
                  checks++;
                  if (exp_q.size() >= DEPTH) begin
                     failures++;
                     $display("FAIL rnd_overflow cyc=%0d queued=%0d", cyc, exp_q.size());
                  end
                  exp_q.push_back({r, req_addr_m, model_pred(r)});
                  model_pc = model_next(req_addr_m, r);
               end
            end else if (outstanding && lat > 0) begin
               lat--;
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_fill();
      test_flush_wait();
      test_flush_coincident();
      test_predecode();
      test_rdy_freeze();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
